// File: rtl/memory_responder.sv
// Word-addressed RAM on the MAR/MDR port with WAIT_STATES cycles of latency and a one-cycle Done pulse.
// Optional macro MEM_COLLISION_ERR_EN: Read=Write=1 raises Err instead of acting as a write.
module memory_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] COUNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, next_state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept, enter_resp;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_write;
  logic              do_write, do_read;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    Done       = 1'b0;
    Busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Read || Write) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            next_state = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        Busy = 1'b1;
        if (count == 4'd0) begin
          next_state = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        Busy       = 1'b1;
        Done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // With zero wait states the RAM is touched on the accepting edge, so use the live inputs there.
  assign acc_addr  = accept ? Address : lat_addr;
  assign acc_data  = accept ? DataIn  : lat_data;
  assign acc_write = accept ? Write   : lat_write;

`ifdef MEM_COLLISION_ERR_EN
  logic lat_collision;
  logic acc_collision;

  assign acc_collision = accept ? (Read && Write) : lat_collision;
  assign do_write      = enter_resp && acc_write && !acc_collision;
  assign do_read       = enter_resp && !acc_write && !acc_collision;
  assign Err           = (state == ST_RESP) && lat_collision;

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear)       lat_collision <= 1'b0;
    else if (accept) lat_collision <= Read && Write;
  end
`else
  assign do_write = enter_resp && acc_write;
  assign do_read  = enter_resp && !acc_write;
  assign Err      = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      count     <= 4'd0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      Mdatain   <= '0;
    end else begin
      if (accept) begin
        count     <= COUNT_INIT;
        lat_addr  <= Address;
        lat_data  <= DataIn;
        lat_write <= Write;
      end else if (state == ST_WAIT && count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (do_read) Mdatain <= mem[acc_addr];
    end
  end

  // RAM contents survive Clear, so this array has no reset.
  always_ff @(posedge Clock) begin
    if (do_write) mem[acc_addr] <= acc_data;
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed scenarios plus random traffic against a word-array model,
// using one instance with two wait states and one with zero wait states.
module tb_memory_responder;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int WS     = 2;
`ifdef MEM_COLLISION_ERR_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              clear;
  logic [1:0]        read_s, write_s;
  logic [ADDR_W-1:0] addr_s [2];
  logic [DATA_W-1:0] data_s [2];
  logic [DATA_W-1:0] mdatain_s [2];
  logic [1:0]        done_s, busy_s, err_s;

  logic [DATA_W-1:0] model_mem [2][512];
  logic [DATA_W-1:0] model_mdatain [2];
  logic [ADDR_W-1:0] pool [8];

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clock = ~clock;

  memory_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS)) dut (
    .Clock(clock), .Clear(clear), .Read(read_s[0]), .Write(write_s[0]),
    .Address(addr_s[0]), .DataIn(data_s[0]), .Mdatain(mdatain_s[0]),
    .Done(done_s[0]), .Busy(busy_s[0]), .Err(err_s[0])
  );

  memory_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(0)) dut_zero (
    .Clock(clock), .Clear(clear), .Read(read_s[1]), .Write(write_s[1]),
    .Address(addr_s[1]), .DataIn(data_s[1]), .Mdatain(mdatain_s[1]),
    .Done(done_s[1]), .Busy(busy_s[1]), .Err(err_s[1])
  );

  task automatic check_output(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One complete handshake; the model decides the outcome before the DUT is observed.
  task automatic apply_stimulus(input int sel, input bit rd, input bit wr,
                                input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input bit toggle);
    int lat;
    bit coll;
    lat  = ((sel == 0) ? WS : 0) + 1;
    coll = rd && wr && COLL_EN;
    @(negedge clock);
    check_output($sformatf("idle_busy%0d", sel), 32'(busy_s[sel]), 32'd0);
    check_output($sformatf("idle_done%0d", sel), 32'(done_s[sel]), 32'd0);
    read_s[sel]  = rd;
    write_s[sel] = wr;
    addr_s[sel]  = a;
    data_s[sel]  = d;
    if (!coll) begin
      if (wr) model_mem[sel][a] = d;
      else    model_mdatain[sel] = model_mem[sel][a];
    end
    @(posedge clock);
    #1;
    if (toggle) begin
      addr_s[sel] = ADDR_W'($urandom);
      data_s[sel] = $urandom;
    end
    for (int k = 1; k <= lat; k++) begin
      @(negedge clock);
      check_output($sformatf("done%0d_c%0d", sel, k), 32'(done_s[sel]), 32'(k == lat));
      check_output($sformatf("busy%0d_c%0d", sel, k), 32'(busy_s[sel]), 32'd1);
      check_output($sformatf("err%0d_c%0d", sel, k), 32'(err_s[sel]), 32'(k == lat && coll));
    end
    check_output($sformatf("mdatain%0d_a%03h", sel, a), mdatain_s[sel], model_mdatain[sel]);
    read_s[sel]  = 1'b0;
    write_s[sel] = 1'b0;
  endtask

  initial begin
    clear   = 1'b1;
    read_s  = '0;
    write_s = '0;
    for (int s = 0; s < 2; s++) begin
      addr_s[s] = '0;
      data_s[s] = '0;
      model_mdatain[s] = '0;
      for (int i = 0; i < 512; i++) model_mem[s][i] = '0;
    end
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check_output($sformatf("rst_mdatain%0d", s), mdatain_s[s], 32'd0);
      check_output($sformatf("rst_done%0d", s), 32'(done_s[s]), 32'd0);
      check_output($sformatf("rst_busy%0d", s), 32'(busy_s[s]), 32'd0);
      check_output($sformatf("rst_err%0d", s), 32'(err_s[s]), 32'd0);
    end
    clear = 1'b0;

    apply_stimulus(0, 1'b0, 1'b1, 9'h010, 32'h8000_0002, 1'b0);
    apply_stimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);
    @(negedge clock);
    check_output("read_hold", mdatain_s[0], 32'h8000_0002);

    // Back-to-back write then read of the top word.
    apply_stimulus(0, 1'b0, 1'b1, 9'h1FF, 32'h4A92_0000, 1'b0);
    apply_stimulus(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);

    // Clear during the wait state discards the pending write.
    @(negedge clock);
    write_s[0] = 1'b1;
    addr_s[0]  = 9'h010;
    data_s[0]  = 32'hDEAD_BEEF;
    @(posedge clock);
    @(negedge clock);
    check_output("abort_busy_before", 32'(busy_s[0]), 32'd1);
    clear = 1'b1;
    #1;
    check_output("abort_done", 32'(done_s[0]), 32'd0);
    check_output("abort_busy", 32'(busy_s[0]), 32'd0);
    check_output("abort_mdatain", mdatain_s[0], 32'd0);
    model_mdatain[0] = '0;
    model_mdatain[1] = '0;
    write_s[0] = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    apply_stimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

    // Simultaneous Read and Write, then read back to see what landed in RAM.
    apply_stimulus(0, 1'b1, 1'b1, 9'h010, 32'h0000_0027, 1'b0);
    apply_stimulus(0, 1'b1, 1'b0, 9'h010, 32'h0, 1'b0);

    // Zero-wait-state instance with inputs scrambled after acceptance.
    apply_stimulus(1, 1'b0, 1'b1, 9'h010, 32'h8000_0002, 1'b1);
    apply_stimulus(1, 1'b1, 1'b0, 9'h010, 32'h0, 1'b1);
    apply_stimulus(1, 1'b0, 1'b1, 9'h000, 32'h1234_5678, 1'b1);
    apply_stimulus(1, 1'b1, 1'b0, 9'h000, 32'h0, 1'b1);

    pool[0] = 9'h000;
    pool[1] = 9'h1FF;
    for (int i = 2; i < 8; i++) pool[i] = ADDR_W'($urandom);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) apply_stimulus(s, 1'b0, 1'b1, pool[i], $urandom, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int s;
      int op;
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      if (op < 4)      apply_stimulus(s, 1'b0, 1'b1, pool[$urandom_range(0, 7)], $urandom, op[0]);
      else if (op < 9) apply_stimulus(s, 1'b1, 1'b0, pool[$urandom_range(0, 7)], 32'h0, op[0]);
      else             apply_stimulus(s, 1'b1, 1'b1, pool[$urandom_range(0, 7)], $urandom, 1'b1);
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
